// File: rtl/bullet_pool_pkg.sv
// bullet_pool_pkg: shared widths, slot count, off-screen sentinels and the
// bullet position payload used by the bullet pool and the collision stage.
package bullet_pool_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned X_W       = 11;
    localparam int unsigned Y_W       = 10;
    localparam int unsigned SLOT_W    = 3;

    // Off-screen position driven by inactive slots so they never collide.
    localparam logic signed [X_W-1:0] SENT_X = X_W'(-16);
    localparam logic signed [Y_W-1:0] SENT_Y = Y_W'(-16);

    typedef struct packed {
        logic signed [X_W-1:0] x;
        logic signed [Y_W-1:0] y;
    } bullet_pos_t;

    // One frame of upward travel, one bit wider so leaving the top shows as a negative result.
    function automatic logic signed [Y_W:0] step_up(
        input logic signed [Y_W-1:0] y,
        input int unsigned           speed
    );
        return (Y_W+1)'(y) - (Y_W+1)'(speed);
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// bullet_pool_if: shot requests, kill reports and per-slot bullet positions.
//   master: frame_tick, fire, gun_x, gun_y, kill_valid, kill_slot out; positions/status in
//   slave : the bullet pool side of the same signals
interface bullet_pool_if;
    import bullet_pool_pkg::*;

    logic                         frame_tick;
    logic                         fire;
    logic signed [X_W-1:0]        gun_x;
    logic signed [Y_W-1:0]        gun_y;
    logic                         kill_valid;
    logic [SLOT_W-1:0]            kill_slot;
    logic [X_W*NUM_SLOTS-1:0]     bullet_x_flat;
    logic [Y_W*NUM_SLOTS-1:0]     bullet_y_flat;
    logic [NUM_SLOTS-1:0]         active;
    logic                         fire_ack;
    logic                         pool_full;

    modport master (
        output frame_tick, fire, gun_x, gun_y, kill_valid, kill_slot,
        input  bullet_x_flat, bullet_y_flat, active, fire_ack, pool_full
    );

    modport slave (
        input  frame_tick, fire, gun_x, gun_y, kill_valid, kill_slot,
        output bullet_x_flat, bullet_y_flat, active, fire_ack, pool_full
    );

endinterface

// File: rtl/bullet_pool_free_slot_finder.sv
// free_slot_finder: combinational lowest-zero priority encoder over the live vector.
//   active     : live slot vector
//   free_slot_c: lowest-index free slot (0 when none is free)
//   any_free_c : at least one slot is free
module free_slot_finder
    import bullet_pool_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] active,
    output logic [SLOT_W-1:0]    free_slot_c,
    output logic                 any_free_c
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_slot_c = '0;
        any_free_c  = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_slot_c = SLOT_W'(i);
                any_free_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: owns the bullet slots; allocates on accepted shots, moves live
// bullets up once per frame, retires bullets leaving the top or reported hit.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): frame_tick, fire, gun_x/gun_y, kill_valid/kill_slot in;
//                bullet_x_flat/bullet_y_flat, active, fire_ack, pool_full out
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int unsigned           NUM_SLOTS = bullet_pool_pkg::NUM_SLOTS,
    parameter int unsigned           SPEED     = 4,
    parameter int unsigned           COOLDOWN  = 8,
    parameter int unsigned           SCREEN_W  = 640,
    parameter logic signed [X_W-1:0] SENT_X    = bullet_pool_pkg::SENT_X,
    parameter logic signed [Y_W-1:0] SENT_Y    = bullet_pool_pkg::SENT_Y
) (
    input  logic          clk,
    input  logic          reset,
    bullet_pool_if.slave  bus
);

    localparam int unsigned CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic [NUM_SLOTS-1:0]     act_q;
    logic [NUM_SLOTS-1:0]     act_d;
    bullet_pos_t              pos_q [NUM_SLOTS];
    logic [CD_W-1:0]          cd_q;
    logic                     fire_ack_q;
    logic                     pool_full_q;
    logic [SLOT_W-1:0]        free_slot_c;
    logic                     any_free_c;
    logic                     gun_ok_c;
    logic                     accept_c;
    logic [X_W*NUM_SLOTS-1:0] x_flat;
    logic [Y_W*NUM_SLOTS-1:0] y_flat;

    // Allocation always looks at the registered live vector.
    free_slot_finder u_finder (
        .active      (act_q),
        .free_slot_c (free_slot_c),
        .any_free_c  (any_free_c)
    );

    // Muzzle must be on screen: 0 <= gun_x < SCREEN_W and gun_y >= 0.
    always_comb begin
        gun_ok_c = !bus.gun_x[X_W-1]
                && (32'(bus.gun_x[X_W-2:0]) < SCREEN_W)
                && !bus.gun_y[Y_W-1];
        accept_c = bus.fire && (cd_q == '0) && any_free_c && gun_ok_c;
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic               slot_act_q;
        logic               slot_act_d;
        bullet_pos_t        slot_pos_q;
        bullet_pos_t        slot_pos_d;
        logic               kill_hit_c;
        logic               alloc_hit_c;
        logic signed [Y_W:0] y_up_c;

        // Slot update priority: kill, then allocation, then frame movement.
        always_comb begin
            kill_hit_c  = bus.kill_valid && (bus.kill_slot == SLOT_W'(i)) && slot_act_q;
            alloc_hit_c = accept_c && (free_slot_c == SLOT_W'(i));
            y_up_c      = step_up(slot_pos_q.y, SPEED);
            slot_act_d  = slot_act_q;
            slot_pos_d  = slot_pos_q;
            if (kill_hit_c) begin
                slot_act_d = 1'b0;
                slot_pos_d = '{x: SENT_X, y: SENT_Y};
            end else if (alloc_hit_c) begin
                slot_act_d = 1'b1;
                slot_pos_d = '{x: bus.gun_x, y: bus.gun_y};
            end else if (bus.frame_tick && slot_act_q) begin
                if (y_up_c[Y_W]) begin
                    slot_act_d = 1'b0;
                    slot_pos_d = '{x: SENT_X, y: SENT_Y};
                end else begin
                    slot_pos_d.y = y_up_c[Y_W-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_act_q <= 1'b0;
                slot_pos_q <= '{x: SENT_X, y: SENT_Y};
            end else begin
                slot_act_q <= slot_act_d;
                slot_pos_q <= slot_pos_d;
            end
        end

        assign act_q[i] = slot_act_q;
        assign act_d[i] = slot_act_d;
        assign pos_q[i] = slot_pos_q;
    end

    // Shot cooldown; a load on acceptance beats a same-cycle frame decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_q <= '0;
        end else if (accept_c) begin
            cd_q <= CD_W'(COOLDOWN);
        end else if (bus.frame_tick && (cd_q != '0)) begin
            cd_q <= cd_q - CD_W'(1);
        end
    end

    // Status flags track the next-state live vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_ack_q  <= 1'b0;
            pool_full_q <= 1'b0;
        end else begin
            fire_ack_q  <= accept_c;
            pool_full_q <= &act_d;
        end
    end

    // Pack slot positions, slot i in the i-th field.
    always_comb begin
        x_flat = '0;
        y_flat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_flat[i*X_W +: X_W] = pos_q[i].x;
            y_flat[i*Y_W +: Y_W] = pos_q[i].y;
        end
    end

    assign bus.bullet_x_flat = x_flat;
    assign bus.bullet_y_flat = y_flat;
    assign bus.active        = act_q;
    assign bus.fire_ack      = fire_ack_q;
    assign bus.pool_full     = pool_full_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed scenarios plus randomized traffic for bullet_pool,
// checked against a slot-list reference model kept in this bench.
module tb_bullet_pool;
    import bullet_pool_pkg::*;

    localparam int SPEED_T    = 4;
    localparam int COOLDOWN_T = 8;
    localparam int SCREEN_T   = 640;
    localparam int SENT       = -16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bullet_pool_if bus ();

    bullet_pool #(
        .NUM_SLOTS (8),
        .SPEED     (SPEED_T),
        .COOLDOWN  (COOLDOWN_T),
        .SCREEN_W  (SCREEN_T),
        .SENT_X    (-11'sd16),
        .SENT_Y    (-10'sd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: a list of slots with plain integer positions.
    bit m_act [8];
    int m_x   [8];
    int m_y   [8];
    int m_cd;
    bit m_ack;
    bit m_full;
    bit pre_act [8];
    bit touched [8];
    int fi;
    int gx_s;
    int gy_s;
    bit acc;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_act[i] = 1'b0; m_x[i] = SENT; m_y[i] = SENT;
            end
            m_cd = 0; m_ack = 1'b0; m_full = 1'b0;
        end else begin
            gx_s = int'(bus.gun_x);
            gy_s = int'(bus.gun_y);
            fi = -1;
            for (int i = 0; i < 8; i++) begin
                pre_act[i] = m_act[i];
                touched[i] = 1'b0;
                if (!m_act[i] && fi < 0) fi = i;
            end
            acc = bus.fire && m_cd == 0 && fi >= 0 && gx_s >= 0 && gx_s < SCREEN_T && gy_s >= 0;
            if (bus.kill_valid && pre_act[int'(bus.kill_slot)]) begin
                m_act[int'(bus.kill_slot)] = 1'b0;
                m_x[int'(bus.kill_slot)] = SENT;
                m_y[int'(bus.kill_slot)] = SENT;
                touched[int'(bus.kill_slot)] = 1'b1;
            end
            if (acc) begin
                m_act[fi] = 1'b1; m_x[fi] = gx_s; m_y[fi] = gy_s; touched[fi] = 1'b1;
            end
            if (bus.frame_tick) begin
                for (int i = 0; i < 8; i++) begin
                    if (pre_act[i] && !touched[i]) begin
                        if (m_y[i] - SPEED_T < 0) begin
                            m_act[i] = 1'b0; m_x[i] = SENT; m_y[i] = SENT;
                        end else begin
                            m_y[i] = m_y[i] - SPEED_T;
                        end
                    end
                end
            end
            if (acc) m_cd = COOLDOWN_T;
            else if (bus.frame_tick && m_cd > 0) m_cd = m_cd - 1;
            m_ack  = acc;
            m_full = 1'b1;
            for (int i = 0; i < 8; i++) if (!m_act[i]) m_full = 1'b0;
        end
    end

    function automatic logic [7:0] model_mask();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_act[i];
        return r;
    endfunction

    function automatic int dut_x(input int i);
        logic signed [10:0] v;
        v = bus.bullet_x_flat[i*11 +: 11];
        return int'(v);
    endfunction

    function automatic int dut_y(input int i);
        logic signed [9:0] v;
        v = bus.bullet_y_flat[i*10 +: 10];
        return int'(v);
    endfunction

    // One clock with the given inputs; returns #1 after the edge.
    task automatic cyc(input bit f, input int gx, input int gy, input bit ft, input bit kv, input int ks);
        bus.fire       = f;
        bus.gun_x      = 11'(gx);
        bus.gun_y      = 10'(gy);
        bus.frame_tick = ft;
        bus.kill_valid = kv;
        bus.kill_slot  = 3'(ks);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1, 320, 400, 1, 0, 0);
        cyc(1, 320, 400, 1, 0, 0);
        n_checks++;
        if (bus.active !== 8'h00 || bus.fire_ack !== 1'b0 || bus.pool_full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: active=%h ack=%b full=%b expected 00/0/0", bus.active, bus.fire_ack, bus.pool_full);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dut_x(i) !== SENT || dut_y(i) !== SENT) begin
                n_errors++;
                $display("FAIL reset_pos slot %0d: got (%0d,%0d) expected (%0d,%0d)", i, dut_x(i), dut_y(i), SENT, SENT);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_shot();
        int bad_x [3] = '{640, -1, 320};
        int bad_y [3] = '{400, 400, -1};
        for (int k = 0; k < 3; k++) begin
            cyc(1, bad_x[k], bad_y[k], 0, 0, 0);
            n_checks++;
            if (bus.fire_ack !== 1'b0 || bus.active !== 8'h00) begin
                n_errors++;
                $display("FAIL reject_gun (%0d,%0d): ack=%b active=%h expected 0/00", bad_x[k], bad_y[k], bus.fire_ack, bus.active);
            end
        end
        cyc(1, 320, 400, 0, 0, 0);
        n_checks++;
        if (bus.fire_ack !== 1'b1 || bus.active !== 8'h01 || dut_x(0) !== 320 || dut_y(0) !== 400) begin
            n_errors++;
            $display("FAIL first_shot: ack=%b active=%h slot0=(%0d,%0d) expected 1/01/(320,400)", bus.fire_ack, bus.active, dut_x(0), dut_y(0));
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.fire_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_pulse: ack=%b expected 0", bus.fire_ack);
        end
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 0);
        n_checks++;
        if (dut_y(0) !== 388 || dut_x(0) !== 320 || bus.active !== 8'h01) begin
            n_errors++;
            $display("FAIL three_frames: slot0=(%0d,%0d) active=%h expected (320,388)/01", dut_x(0), dut_y(0), bus.active);
        end
    endtask

    task automatic test_cooldown();
        bit exp_ack;
        do_reset();
        for (int f = 0; f < 20; f++) begin
            cyc(1, 100, 400, 1, 0, 0);
            exp_ack = (f == 0 || f == 9 || f == 18);
            n_checks++;
            if (bus.fire_ack !== exp_ack) begin
                n_errors++;
                $display("FAIL cooldown_frame %0d: ack=%b expected %b", f, bus.fire_ack, exp_ack);
            end
            cyc(0, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if (bus.active !== 8'h07 || dut_y(0) !== 324 || dut_y(1) !== 360 || dut_y(2) !== 396 || dut_x(2) !== 100) begin
            n_errors++;
            $display("FAIL cooldown_end: active=%h y=(%0d,%0d,%0d) x2=%0d expected 07 y=(324,360,396) x2=100",
                     bus.active, dut_y(0), dut_y(1), dut_y(2), dut_x(2));
        end
    endtask

    task automatic test_pool_full();
        logic [7:0] exp_mask;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            cyc(1, 50 + s, 480, 0, 0, 0);
            exp_mask = 8'((16'd1 << (s + 1)) - 16'd1);
            n_checks++;
            if (bus.fire_ack !== 1'b1 || bus.active !== exp_mask || bus.pool_full !== (s == 7) || dut_x(s) !== 50 + s) begin
                n_errors++;
                $display("FAIL fill_slot %0d: ack=%b active=%h full=%b x=%0d expected 1/%h/%b/%0d",
                         s, bus.fire_ack, bus.active, bus.pool_full, dut_x(s), exp_mask, s == 7, 50 + s);
            end
            for (int t = 0; t < COOLDOWN_T; t++) cyc(0, 0, 0, 1, 0, 0);
        end
        cyc(1, 300, 300, 0, 0, 0);
        n_checks++;
        if (bus.fire_ack !== 1'b0 || bus.active !== 8'hFF || bus.pool_full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_reject: ack=%b active=%h full=%b expected 0/FF/1", bus.fire_ack, bus.active, bus.pool_full);
        end
        cyc(0, 0, 0, 0, 1, 5);
        n_checks++;
        if (bus.active !== 8'hDF || bus.pool_full !== 1'b0 || dut_x(5) !== SENT || dut_y(5) !== SENT) begin
            n_errors++;
            $display("FAIL kill_5: active=%h full=%b slot5=(%0d,%0d) expected DF/0/(-16,-16)", bus.active, bus.pool_full, dut_x(5), dut_y(5));
        end
        cyc(1, 300, 300, 0, 0, 0);
        n_checks++;
        if (bus.fire_ack !== 1'b1 || bus.active !== 8'hFF || dut_x(5) !== 300 || dut_y(5) !== 300) begin
            n_errors++;
            $display("FAIL refill_5: ack=%b active=%h slot5=(%0d,%0d) expected 1/FF/(300,300)", bus.fire_ack, bus.active, dut_x(5), dut_y(5));
        end
    endtask

    task automatic test_top_exit();
        do_reset();
        cyc(1, 10, 36, 0, 0, 0);
        for (int t = 0; t < COOLDOWN_T; t++) cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 20, 3, 0, 0, 0);
        n_checks++;
        if (bus.active !== 8'h03 || dut_y(0) !== 4 || dut_y(1) !== 3) begin
            n_errors++;
            $display("FAIL exit_setup: active=%h y0=%0d y1=%0d expected 03/4/3", bus.active, dut_y(0), dut_y(1));
        end
        cyc(0, 0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active !== 8'h01 || dut_y(0) !== 0 || dut_x(0) !== 10 || dut_x(1) !== SENT || dut_y(1) !== SENT) begin
            n_errors++;
            $display("FAIL exit_edge: active=%h slot0=(%0d,%0d) slot1=(%0d,%0d) expected 01/(10,0)/(-16,-16)",
                     bus.active, dut_x(0), dut_y(0), dut_x(1), dut_y(1));
        end
        cyc(0, 0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active !== 8'h00 || dut_x(0) !== SENT || dut_y(0) !== SENT) begin
            n_errors++;
            $display("FAIL exit_zero: active=%h slot0=(%0d,%0d) expected 00/(-16,-16)", bus.active, dut_x(0), dut_y(0));
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cyc(1, 10, 200, 0, 0, 0);
        for (int t = 0; t < COOLDOWN_T; t++) cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 20, 300, 0, 0, 0);
        for (int t = 0; t < COOLDOWN_T; t++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 7);
        n_checks++;
        if (bus.active !== 8'h03 || dut_y(0) !== 136 || dut_y(1) !== 268) begin
            n_errors++;
            $display("FAIL kill_inactive: active=%h y0=%0d y1=%0d expected 03/136/268", bus.active, dut_y(0), dut_y(1));
        end
        cyc(1, 30, 100, 1, 1, 0);
        n_checks++;
        if (bus.fire_ack !== 1'b1 || bus.active !== 8'h06 || dut_x(0) !== SENT || dut_y(0) !== SENT
            || dut_y(1) !== 264 || dut_x(2) !== 30 || dut_y(2) !== 100) begin
            n_errors++;
            $display("FAIL same_cycle: ack=%b active=%h s0=(%0d,%0d) y1=%0d s2=(%0d,%0d) expected 1/06/(-16,-16)/264/(30,100)",
                     bus.fire_ack, bus.active, dut_x(0), dut_y(0), dut_y(1), dut_x(2), dut_y(2));
        end
    endtask

    task automatic test_random();
        int gy;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 255) == 0);
            gy = int'($urandom_range(0, 541)) - 30;
            if (gy > 511) gy = 511;
            cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 759)) - 60, gy,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, int'($urandom_range(0, 7)));
            n_checks++;
            if (bus.active !== model_mask() || bus.fire_ack !== m_ack || bus.pool_full !== m_full) begin
                n_errors++;
                $display("FAIL random_flags cycle %0d: active=%h ack=%b full=%b expected %h/%b/%b",
                         c, bus.active, bus.fire_ack, bus.pool_full, model_mask(), m_ack, m_full);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (dut_x(i) !== m_x[i] || dut_y(i) !== m_y[i]) begin
                    n_errors++;
                    $display("FAIL random_pos cycle %0d slot %0d: got (%0d,%0d) expected (%0d,%0d)",
                             c, i, dut_x(i), dut_y(i), m_x[i], m_y[i]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.fire = 1'b0; bus.gun_x = '0; bus.gun_y = '0;
        bus.frame_tick = 1'b0; bus.kill_valid = 1'b0; bus.kill_slot = '0;
        test_reset();
        test_first_shot();
        test_cooldown();
        test_pool_full();
        test_top_exit();
        test_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
